// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: angle and gain tables, mode codes,
// FSM state type and small helpers for deriving Z_W-scaled constants.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // atan(2^-i) * 2^31 / pi, i.e. a 32-bit angle where 2^32 is one full turn
  localparam logic [31:0] ATAN32 [32] = '{
    32'd536870912,
    32'd316933406,
    32'd167458907,
    32'd85004756,
    32'd42667331,
    32'd21354465,
    32'd10679838,
    32'd5340245,
    32'd2670163,
    32'd1335087,
    32'd667544,
    32'd333772,
    32'd166886,
    32'd83443,
    32'd41722,
    32'd20861,
    32'd10430,
    32'd5215,
    32'd2608,
    32'd1304,
    32'd652,
    32'd326,
    32'd163,
    32'd81,
    32'd41,
    32'd20,
    32'd10,
    32'd5,
    32'd3,
    32'd1,
    32'd1,
    32'd0
  };

  // round(2^17 * prod_{i<n} 1/sqrt(1+2^-2i)), indexed by iteration count n
  localparam logic [17:0] GAIN_K17 [32] = '{
    18'd131072,
    18'd92682,
    18'd82897,
    18'd80422,
    18'd79801,
    18'd79646,
    18'd79607,
    18'd79597,
    18'd79595,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594,
    18'd79594
  };

  // pi/2 in a zw-bit angle word
  function automatic logic [31:0] quarter(input int zw);
    return 32'd1 << (zw - 2);
  endfunction

  // Table entry rescaled to a zw-bit angle word with round-half-up
  function automatic logic [31:0] atan_scaled(input int idx, input int zw);
    logic [32:0] acc;
    if (zw >= 32) begin
      return ATAN32[idx];
    end
    acc = {1'b0, ATAN32[idx]} + (33'd1 << (31 - zw));
    return 32'(acc >> (32 - zw));
  endfunction

endpackage

// File: rtl/cordic_iter.sv
// One CORDIC micro-rotation: direction chosen from z (rotation) or y (vectoring),
// shift amount supplied at runtime by the engine's iteration counter.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W    = 20,
  parameter int ZW   = 16,
  parameter int SH_W = 5
) (
  input  logic                 mode,
  input  logic [SH_W-1:0]      shift,
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [ZW-1:0] z,
  input  logic signed [ZW-1:0] atan,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic                d_pos;

  always_comb begin
    x_sh  = x >>> shift;
    y_sh  = y >>> shift;
    // d = +1 rotates counter-clockwise and consumes positive angle
    d_pos = (mode == MODE_ROT) ? ~z[ZW-1] : y[W-1];
    if (d_pos) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine with quadrant pre-rotation and valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation state before DONE.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int XY_W = 18,
  parameter int Z_W  = 16,
  parameter int ITER = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic signed [XY_W-1:0]   in_x,
  input  logic signed [XY_W-1:0]   in_y,
  input  logic signed [Z_W-1:0]    in_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [XY_W+1:0]   out_x,
  output logic signed [XY_W+1:0]   out_y,
  output logic signed [Z_W-1:0]    out_z,
  output logic                     busy
);

  localparam int W     = XY_W + 2;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
  localparam logic [31:0] QUARTER32 = quarter(Z_W);
  localparam logic signed [Z_W-1:0] QUARTER = QUARTER32[Z_W-1:0];

  state_t                 state_reg;
  logic                   mode_reg;
  logic [CNT_W-1:0]       iter_reg;
  logic signed [W-1:0]    x_reg;
  logic signed [W-1:0]    y_reg;
  logic signed [Z_W-1:0]  z_reg;
  logic                   out_valid_reg;
  logic signed [W-1:0]    out_x_reg;
  logic signed [W-1:0]    out_y_reg;
  logic signed [Z_W-1:0]  out_z_reg;

  logic signed [W-1:0]    x_ext;
  logic signed [W-1:0]    y_ext;
  logic signed [W-1:0]    x_pre;
  logic signed [W-1:0]    y_pre;
  logic signed [Z_W-1:0]  z_pre;
  logic signed [W-1:0]    x_next;
  logic signed [W-1:0]    y_next;
  logic signed [Z_W-1:0]  z_next;
  logic signed [Z_W-1:0]  atan_lut [32];
  logic signed [Z_W-1:0]  atan_cur;

  // Per-iteration angle constants, rescaled from the 32-bit table at elaboration
  for (genvar gi = 0; gi < 32; gi++) begin : g_atan
    localparam logic [31:0] ATAN_GI = atan_scaled(gi, Z_W);
    assign atan_lut[gi] = ATAN_GI[Z_W-1:0];
  end

  assign atan_cur = atan_lut[iter_reg];

  // Fold the input into the right half-plane (vector) or |z| <= pi/2 (rotation)
  // so the micro-rotations only have to cover about +-100 degrees.
  always_comb begin
    x_ext = {{2{in_x[XY_W-1]}}, in_x};
    y_ext = {{2{in_y[XY_W-1]}}, in_y};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = in_z;
    if (in_mode == MODE_ROT) begin
      if (in_z > QUARTER) begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = in_z - QUARTER;
      end else if (in_z < -QUARTER) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = in_z + QUARTER;
      end
    end else if (in_x[XY_W-1]) begin
      if (!in_y[XY_W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = in_z + QUARTER;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = in_z - QUARTER;
      end
    end
  end

  cordic_iter #(
    .W    (W),
    .ZW   (Z_W),
    .SH_W (CNT_W)
  ) u_iter (
    .mode   (mode_reg),
    .shift  (iter_reg),
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .atan   (atan_cur),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [17:0] GAIN_K = GAIN_K17[ITER];
  localparam int PW = W + 19;

  // v * K / 2^17 with round-half-up, saturated back to W bits
  function automatic logic signed [W-1:0] gain_scale(input logic signed [W-1:0] v);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [W+1:0]  q;
    prod = v * $signed({1'b0, GAIN_K});
    rnd  = prod + $signed({{(W+2){1'b0}}, 17'h10000});
    q    = rnd[PW-1:17];
    if (q[W+1:W-1] == 3'b000 || q[W+1:W-1] == 3'b111) begin
      return q[W-1:0];
    end else if (q[W+1]) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return {1'b0, {(W-1){1'b1}}};
    end
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_ROT;
      iter_reg      <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      out_z_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            mode_reg  <= in_mode;
            x_reg     <= x_pre;
            y_reg     <= y_pre;
            z_reg     <= z_pre;
            iter_reg  <= '0;
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          x_reg    <= x_next;
          y_reg    <= y_next;
          z_reg    <= z_next;
          iter_reg <= iter_reg + CNT_W'(1);
          if (iter_reg == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_reg <= ST_COMP;
`else
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            out_x_reg     <= x_next;
            out_y_reg     <= y_next;
            out_z_reg     <= z_next;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: begin
          state_reg     <= ST_DONE;
          out_valid_reg <= 1'b1;
          out_x_reg     <= gain_scale(x_reg);
          out_y_reg     <= gain_scale(y_reg);
          out_z_reg     <= z_reg;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign busy      = (state_reg != ST_IDLE);
  assign out_valid = out_valid_reg;
  assign out_x     = out_x_reg;
  assign out_y     = out_y_reg;
  assign out_z     = out_z_reg;

endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine at XY_W=18, Z_W=16, ITER=16.
// Expected magnitudes switch with CORDIC_GAIN_COMP_EN.
module tb_cordic_engine;

  localparam int XY_W = 18;
  localparam int Z_W  = 16;
  localparam int ITER = 16;
  localparam int W    = XY_W + 2;
  localparam int TOL_XY = ITER + 2;
  localparam int TOL_Z  = ITER;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
  localparam int GAP = ITER + 3;
  localparam int G_AXIS = 32768;
  localparam int G_DIAG = 23170;
  localparam int G_VEC  = 28284;
`else
  localparam int LAT = ITER;
  localparam int GAP = ITER + 2;
  localparam int G_AXIS = 53961;
  localparam int G_DIAG = 38156;
  localparam int G_VEC  = 46577;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_mode = 1'b0;
  logic signed [XY_W-1:0] in_x = '0;
  logic signed [XY_W-1:0] in_y = '0;
  logic signed [Z_W-1:0]  in_z = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [W-1:0]    out_x;
  logic signed [W-1:0]    out_y;
  logic signed [Z_W-1:0]  out_z;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  cordic_engine #(
    .XY_W (XY_W),
    .Z_W  (Z_W),
    .ITER (ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int x;
    int y;
    int z;
    int ex;
    int ey;
    int ez;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Bring a wrapped angle into the 2^Z_W window centred on the expected value
  function automatic int wrap_near(input int got, input int exp);
    logic signed [Z_W-1:0] d;
    d = Z_W'(got - exp);
    return exp + int'(d);
  endfunction

  task automatic send(input int m, input int x, input int y, input int z);
    int n;
    n = 0;
    in_mode  = m[0];
    in_x     = XY_W'(x);
    in_y     = XY_W'(y);
    in_z     = Z_W'(z);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int lat;
    send(vecs[idx].mode, vecs[idx].x, vecs[idx].y, vecs[idx].z);
    wait_result(lat);
    check("latency", lat, LAT, 0);
    check("out_x", out_x, vecs[idx].ex, TOL_XY);
    check("out_y", out_y, vecs[idx].ey, TOL_XY);
    check("out_z", wrap_near(int'(out_z), vecs[idx].ez), vecs[idx].ez, TOL_Z);
    $display("vec %0d mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) exp=(%0d,%0d,%0d) lat=%0d",
             idx, vecs[idx].mode, vecs[idx].x, vecs[idx].y, vecs[idx].z,
             out_x, out_y, out_z, vecs[idx].ex, vecs[idx].ey, vecs[idx].ez, lat);
    take();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nchg;
    int nval;
    int acc_cnt;
    int acc_at[4];
    logic signed [W-1:0]   px;
    logic signed [W-1:0]   py;
    logic signed [Z_W-1:0] pz;

    vecs[0] = '{0,  32768,     0,      0, G_AXIS,       0,      0};
    vecs[1] = '{0,  32768,     0,  16384,      0,  G_AXIS,      0};
    vecs[2] = '{0,  32768,     0, -24576, -G_DIAG, -G_DIAG,     0};
    vecs[3] = '{1, -32768,     0,      0, G_AXIS,       0, -32768};
    vecs[4] = '{1,  20000, 20000,      0, G_VEC,        0,   8192};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0, 0);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_out_x", out_x, 0, 0);
    check("rst_out_z", out_z, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1, 0);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_vec(i);
    end

    // Backpressure: result held for 5 cycles while a new sample waits
    send(0, 32768, 0, 0);
    wait_result(lat);
    px = out_x;
    py = out_y;
    pz = out_z;
    in_valid = 1'b1;
    in_x = XY_W'(-1000);
    in_y = XY_W'(500);
    in_z = Z_W'(1234);
    nchg = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_x !== px || out_y !== py || out_z !== pz) nchg++;
      check("hold_out_valid", out_valid, 1, 0);
      check("hold_in_ready", in_ready, 0, 0);
    end
    check("hold_changes", nchg, 0, 0);
    check("hold_out_x", out_x, G_AXIS, TOL_XY);
    $display("backpressure hold out=(%0d,%0d,%0d) changes=%0d", out_x, out_y, out_z, nchg);
    in_valid = 1'b0;
    take();
    @(negedge clk);
    check("release_in_ready", in_ready, 1, 0);
    check("release_busy", busy, 0, 0);
    check("release_out_valid", out_valid, 0, 0);

    // Reset mid-BUSY aborts the sample
    send(0, 32768, 0, 16384);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0, 0);
    check("abort_out_x", out_x, 0, 0);
    check("abort_out_y", out_y, 0, 0);
    check("abort_out_z", out_z, 0, 0);
    check("abort_busy", busy, 0, 0);
    check("abort_in_ready", in_ready, 1, 0);
    nval = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (out_valid) nval++;
    end
    check("abort_no_valid", nval, 0, 0);
    $display("reset abort: out_valid seen %0d times after reset", nval);
    run_vec(1);

    // Back-to-back: accepts spaced by GAP cycles
    @(negedge clk);
    in_mode   = 1'b0;
    in_x      = XY_W'(10000);
    in_y      = XY_W'(0);
    in_z      = Z_W'(4096);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc_cnt = 0;
    for (int k = 0; k < 4; k++) acc_at[k] = 0;
    for (int k = 0; k < 4 * GAP + 20 && acc_cnt < 4; k++) begin
      if (in_valid && in_ready) begin
        acc_at[acc_cnt] = k;
        acc_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 4, 0);
    for (int k = 1; k < 4; k++) begin
      check("b2b_gap", acc_at[k] - acc_at[k-1], GAP, 0);
      $display("back-to-back accept %0d at cycle %0d gap %0d", k, acc_at[k], acc_at[k] - acc_at[k-1]);
    end
    repeat (GAP + 4) @(negedge clk);
    out_ready = 1'b0;
    check("b2b_drained", busy, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
